// File: rtl/ising_lattice_engine.sv
// Checkerboard Metropolis engine for an N x N periodic Ising lattice, one lattice row per cycle.
// Sweep = WHITE, GREY, MEAS passes of N cycles each plus one observe cycle; start/load only taken in IDLE.

module ising_lattice_engine #(
    parameter int N  = 32,
    parameter int SW = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_en,
    input  logic [$clog2(N)-1:0]          load_row,
    input  logic [N-1:0]                  load_data,
    input  logic [$clog2(N)-1:0]          rd_row,
    output logic [N-1:0]                  rd_data,
    input  logic [15:0]                   seed,
    input  logic [15:0]                   thr4,
    input  logic [15:0]                   thr8,
    input  logic [SW-1:0]                 num_sweeps,
    input  logic                          start,
    output logic                          busy,
    output logic                          obs_valid,
    output logic signed [$clog2(N*N)+2:0] energy,
    output logic signed [$clog2(N*N)+1:0] mag,
    output logic [SW-1:0]                 sweep_count,
    output logic                          done
);
    localparam int RW = $clog2(N);
    localparam int EW = $clog2(N*N) + 3;
    localparam int MW = $clog2(N*N) + 2;
    localparam int CW = $clog2(2*N) + 1;
    localparam logic [15:0]  LFSR_MASK = 16'hB400;
    localparam logic [15:0]  LFSR_ALT  = 16'hACE1;
    localparam logic [N-1:0] EVEN_COLS = {(N/2){2'b01}};

    typedef enum logic [2:0] {S_IDLE, S_WHITE, S_GREY, S_MEAS, S_OBS} state_t;

    state_t               state_q;
    logic [RW-1:0]        row_q;
    logic [N-1:0]         lat_q [N];
    logic [15:0]          lfsr_q [N];
    logic [15:0]          thr4_q, thr8_q;
    logic [SW-1:0]        nsw_q;
    logic                 zero_run_q;
    logic signed [EW-1:0] acc_e_q, energy_q;
    logic signed [MW-1:0] acc_m_q, mag_q;
    logic [SW-1:0]        sweep_q;
    logic                 obs_q, done_q;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ LFSR_MASK) : (x >> 1);
    endfunction

    function automatic logic [15:0] lfsr_seed(input logic [15:0] x);
        return (x == 16'h0000) ? LFSR_ALT : x;
    endfunction

    logic [N-1:0]         row_up, row_cur, row_dn, row_l, row_r;
    logic [N-1:0]         eq_u, eq_d, eq_l, eq_r;
    logic [N-1:0]         upd_mask, flip, new_row;
    logic [2:0]           agree;
    logic [CW-1:0]        bond_eq, ones;
    logic signed [EW-1:0] acc_e_d;
    logic signed [MW-1:0] acc_m_d;
    logic [SW-1:0]        sweep_inc;
    logic                 row_last;

    always_comb begin
        row_up  = lat_q[row_q - RW'(1)];
        row_cur = lat_q[row_q];
        row_dn  = lat_q[row_q + RW'(1)];
        // row_r[c] holds column c+1, row_l[c] holds column c-1, both wrapping
        row_r   = {row_cur[0], row_cur[N-1:1]};
        row_l   = {row_cur[N-2:0], row_cur[N-1]};
        eq_u    = ~(row_cur ^ row_up);
        eq_d    = ~(row_cur ^ row_dn);
        eq_l    = ~(row_cur ^ row_l);
        eq_r    = ~(row_cur ^ row_r);
        upd_mask = (row_q[0] ^ (state_q == S_GREY)) ? ~EVEN_COLS : EVEN_COLS;
        flip  = '0;
        agree = '0;
        // agree = neighbours equal to the site; dE = 4*agree - 8
        for (int c = 0; c < N; c++) begin
            agree = {2'b00, eq_u[c]} + {2'b00, eq_d[c]} + {2'b00, eq_l[c]} + {2'b00, eq_r[c]};
            flip[c] = (agree <= 3'd2)
                   || ((agree == 3'd3) && (lfsr_q[c] < thr4_q))
                   || ((agree == 3'd4) && (lfsr_q[c] < thr8_q));
        end
        new_row = row_cur ^ (flip & upd_mask);
        bond_eq = CW'($countones(eq_r)) + CW'($countones(eq_d));
        ones    = CW'($countones(row_cur));
        // row bond sum is 2*bond_eq - 2N; energy subtracts it
        acc_e_d = ((row_q == '0) ? '0 : acc_e_q) + EW'(2*N) - (EW'(bond_eq) << 1);
        acc_m_d = ((row_q == '0) ? '0 : acc_m_q) + (MW'(ones) << 1) - MW'(N);
    end

    assign sweep_inc = sweep_q + SW'(1);
    assign row_last  = (row_q == RW'(N-1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            for (int r = 0; r < N; r++) lat_q[r] <= '0;
            for (int c = 0; c < N; c++) lfsr_q[c] <= lfsr_seed(LFSR_ALT ^ 16'(c));
            thr4_q     <= '0;
            thr8_q     <= '0;
            nsw_q      <= '0;
            zero_run_q <= 1'b0;
            acc_e_q    <= '0;
            acc_m_q    <= '0;
            energy_q   <= '0;
            mag_q      <= '0;
            sweep_q    <= '0;
            obs_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            obs_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_en) lat_q[load_row] <= load_data;
                    if (start) begin
                        for (int c = 0; c < N; c++) lfsr_q[c] <= lfsr_seed(seed ^ 16'(c));
                        thr4_q     <= thr4;
                        thr8_q     <= thr8;
                        nsw_q      <= num_sweeps;
                        zero_run_q <= (num_sweeps == '0);
                        sweep_q    <= '0;
                        row_q      <= '0;
                        state_q    <= (num_sweeps == '0) ? S_MEAS : S_WHITE;
                    end
                end
                S_WHITE, S_GREY: begin
                    lat_q[row_q] <= new_row;
                    for (int c = 0; c < N; c++) lfsr_q[c] <= lfsr_step(lfsr_q[c]);
                    row_q <= row_q + RW'(1);
                    if (row_last) state_q <= (state_q == S_WHITE) ? S_GREY : S_MEAS;
                end
                S_MEAS: begin
                    acc_e_q <= acc_e_d;
                    acc_m_q <= acc_m_d;
                    row_q   <= row_q + RW'(1);
                    if (row_last) state_q <= S_OBS;
                end
                S_OBS: begin
                    energy_q <= acc_e_q;
                    mag_q    <= acc_m_q;
                    obs_q    <= 1'b1;
                    if (!zero_run_q) sweep_q <= sweep_inc;
                    if (zero_run_q || (sweep_inc == nsw_q)) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_WHITE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_data     = lat_q[rd_row];
    assign busy        = (state_q != S_IDLE);
    assign obs_valid   = obs_q;
    assign done        = done_q;
    assign energy      = energy_q;
    assign mag         = mag_q;
    assign sweep_count = sweep_q;

endmodule

// File: tb/tb_ising_lattice_engine.sv
// Randomised and directed checks of ising_lattice_engine (N=4) against a whole-lattice Metropolis model.

module tb_ising_lattice_engine;
    localparam int N = 4;
    localparam int P = 3*N + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load_en = 1'b0;
    logic [1:0]        load_row = '0;
    logic [N-1:0]      load_data = '0;
    logic [1:0]        rd_row = '0;
    logic [N-1:0]      rd_data;
    logic [15:0]       seed = '0, thr4 = '0, thr8 = '0;
    logic [15:0]       num_sweeps = '0;
    logic              start = 1'b0;
    logic              busy, obs_valid, done;
    logic signed [6:0] energy;
    logic signed [5:0] mag;
    logic [15:0]       sweep_count;

    int          total = 0;
    int          bad = 0;
    int          m [N][N];
    logic [15:0] rng [N];
    logic [15:0] m_thr4, m_thr8;
    int          exp_e [1:8];
    int          exp_m [1:8];

    ising_lattice_engine #(.N(N), .SW(16)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_row(load_row),
        .load_data(load_data), .rd_row(rd_row), .rd_data(rd_data), .seed(seed),
        .thr4(thr4), .thr8(thr8), .num_sweeps(num_sweeps), .start(start),
        .busy(busy), .obs_valid(obs_valid), .energy(energy), .mag(mag),
        .sweep_count(sweep_count), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    task automatic model_set_row(input int r, input logic [N-1:0] d);
        for (int c = 0; c < N; c++) m[r][c] = d[c] ? 1 : -1;
    endtask

    function automatic logic [N-1:0] model_row(input int r);
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = (m[r][c] > 0);
        return v;
    endfunction

    // Metropolis sweep: white colour then grey colour; column c's generator steps once per row visited
    task automatic model_sweep;
        int s, nb, de;
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if ((r + c) % 2 == p) begin
                        s  = m[r][c];
                        nb = m[(r+N-1)%N][c] + m[(r+1)%N][c] + m[r][(c+N-1)%N] + m[r][(c+1)%N];
                        de = 2 * s * nb;
                        if (de <= 0 || (de == 4 && rng[c] < m_thr4) || (de == 8 && rng[c] < m_thr8))
                            m[r][c] = -s;
                    end
                end
                for (int c = 0; c < N; c++) rng[c] = lstep(rng[c]);
            end
        end
    endtask

    function automatic int model_energy;
        int e = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                e -= m[r][c] * (m[r][(c+1)%N] + m[(r+1)%N][c]);
        return e;
    endfunction

    function automatic int model_mag;
        int s = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) s += m[r][c];
        return s;
    endfunction

    task automatic do_load(input int r, input logic [N-1:0] d);
        load_en = 1'b1; load_row = 2'(r); load_data = d;
        tick;
        load_en = 1'b0;
        model_set_row(r, d);
    endtask

    task automatic load_random;
        for (int r = 0; r < N; r++) do_load(r, 4'($urandom));
    endtask

    task automatic check_lattice(input string tag);
        for (int r = 0; r < N; r++) begin
            rd_row = 2'(r);
            #1;
            chk(tag, rd_data, model_row(r));
        end
    endtask

    task automatic do_reset;
        start = 1'b0; load_en = 1'b0;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        for (int r = 0; r < N; r++) model_set_row(r, '0);
        tick;
    endtask

    task automatic run(input logic [15:0] sd, input logic [15:0] t4, input logic [15:0] t8,
                       input int nsw, input bit disturb, input bit lws, input int lr,
                       input logic [N-1:0] ld);
        int nobs, period, len, k, last_e, last_m, last_s;
        bit obs_exp;
        m_thr4 = t4; m_thr8 = t8;
        if (lws) model_set_row(lr, ld);
        for (int c = 0; c < N; c++)
            rng[c] = ((sd ^ 16'(c)) == 16'h0) ? 16'hACE1 : (sd ^ 16'(c));
        nobs   = (nsw == 0) ? 1 : nsw;
        period = (nsw == 0) ? N + 1 : P;
        len    = nobs * period;
        for (int j = 1; j <= nobs; j++) begin
            if (nsw > 0) model_sweep();
            exp_e[j] = model_energy();
            exp_m[j] = model_mag();
        end
        seed = sd; thr4 = t4; thr8 = t8; num_sweeps = 16'(nsw);
        start = 1'b1; load_en = lws; load_row = 2'(lr); load_data = ld;
        tick;
        start = 1'b0; load_en = 1'b0;
        last_e = exp_e[nobs]; last_m = exp_m[nobs]; last_s = (nsw == 0) ? 0 : nsw;
        for (int cyc = 1; cyc <= len; cyc++) begin
            tick;
            obs_exp = (cyc % period == 0);
            chk("obs_valid", obs_valid, obs_exp);
            chk("done", done, cyc == len);
            if (cyc < len) chk("busy_run", busy, 1);
            if (obs_exp) begin
                k = cyc / period;
                chk("energy", energy, exp_e[k]);
                chk("mag", mag, exp_m[k]);
                chk("sweep_count", sweep_count, (nsw == 0) ? 0 : k);
            end
            if (disturb && cyc < len) begin
                start = 1'($urandom); load_en = 1'($urandom);
                load_row = 2'($urandom); load_data = 4'($urandom);
                seed = 16'($urandom); thr4 = 16'($urandom); thr8 = 16'($urandom);
                num_sweeps = 16'($urandom_range(0, 5));
            end else begin
                start = 1'b0; load_en = 1'b0;
            end
        end
        start = 1'b0; load_en = 1'b0;
        tick;
        chk("busy_after", busy, 0);
        chk("obs_after", obs_valid, 0);
        chk("done_after", done, 0);
        tick;
        chk("energy_hold", energy, last_e);
        chk("mag_hold", mag, last_m);
        chk("sweep_hold", sweep_count, last_s);
        check_lattice("lattice");
    endtask

    initial begin
        tick;
        tick;
        reset = 1'b0;
        for (int r = 0; r < N; r++) model_set_row(r, '0);
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_obs", obs_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_energy", energy, 0);
        chk("rst_mag", mag, 0);
        chk("rst_sweep", sweep_count, 0);
        check_lattice("rst_lattice");

        // all +1, no thermal flips: 13-cycle latency, ground-state observables
        for (int r = 0; r < N; r++) do_load(r, 4'hF);
        run(16'h0001, 16'h0, 16'h0, 1, 0, 0, 0, '0);
        chk("allup_energy", energy, -32);
        chk("allup_mag", mag, 16);
        chk("allup_sweep", sweep_count, 1);

        // checkerboard with (0,0)=+1: white pass flips everything it touches
        do_load(0, 4'b0101); do_load(1, 4'b1010); do_load(2, 4'b0101); do_load(3, 4'b1010);
        run(16'h1234, 16'h0, 16'h0, 1, 0, 0, 0, '0);
        chk("cb_mag", mag, -16);
        chk("cb_energy", energy, -32);

        // measurement-only run straight after reset
        do_reset;
        run(16'($urandom), 16'($urandom), 16'($urandom), 0, 0, 0, 0, '0);
        chk("meas_energy", energy, -32);
        chk("meas_mag", mag, -16);
        chk("meas_sweep", sweep_count, 0);

        // three sweeps, random lattice and thresholds
        load_random;
        run(16'($urandom), 16'($urandom), 16'($urandom), 3, 0, 0, 0, '0);

        // seed value that maps column 0 to the alternate LFSR start
        load_random;
        run(16'h0000, 16'h8000, 16'h4000, 2, 0, 0, 0, '0);

        // busy-time start/load must be ignored
        load_random;
        run(16'($urandom), 16'($urandom), 16'($urandom), 2, 1, 0, 0, '0);

        // randomised runs, some loading a row in the start cycle
        for (int i = 0; i < 6; i++) begin
            load_random;
            run(16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(1, 3),
                1'($urandom), 1'($urandom), $urandom_range(0, N-1), 4'($urandom));
        end

        // asynchronous reset in the GREY pass aborts silently
        load_random;
        seed = 16'h5A5A; thr4 = 16'h7000; thr8 = 16'h2000; num_sweeps = 16'd2;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick;
        chk("grey_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_obs", obs_valid, 0);
        chk("abort_done", done, 0);
        for (int r = 0; r < N; r++) model_set_row(r, '0);
        check_lattice("abort_lattice");
        tick;
        reset = 1'b0;
        for (int i = 0; i < 3*P; i++) begin
            tick;
            chk("abort_no_done", done, 0);
            chk("abort_no_obs", obs_valid, 0);
        end
        chk("abort_sweep", sweep_count, 0);

        load_random;
        run(16'($urandom), 16'($urandom), 16'($urandom), 1, 0, 0, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
